// File: rtl/memory_arbiter.sv
// ============================================================================
// Module   : memory_arbiter
// Brief    : Two-requester (fetch / data) arbiter in front of a single-port
//            memory controller. Each grant runs IDLE -> ACCESS -> DONE, so a
//            request is acknowledged two cycles after it is sampled.
// Options  : MEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are
//            resolved round-robin; otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_winner;      // 0 = requester 0, 1 = requester 1
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [DATA_W-1:0]   r_mem_data_in;
    logic                r_mem_we;
    logic                w_any_req;
    logic                w_grant1;      // requester 1 wins this arbitration

    assign w_any_req = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer names the requester favoured on a tie; 0 after reset.
    logic r_rr_ptr;

    assign w_grant1 = req1 & (~req0 | r_rr_ptr);

    // Hand priority to the other requester after every grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_rr_ptr <= ~w_grant1;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is silent.
    assign w_grant1 = req1 & ~req0;
`endif

    // Grant sequencing: latch the winner's access, run it, then acknowledge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_winner      <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata       <= '0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_we      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (w_any_req) begin
                        // Only the winner's inputs reach the memory bus.
                        r_winner      <= w_grant1;
                        r_mem_address <= w_grant1 ? addr1  : addr0;
                        r_mem_data_in <= w_grant1 ? wdata1 : wdata0;
                        r_mem_we      <= w_grant1 ? we1    : we0;
                        r_state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Controller completed its falling-edge access mid-cycle.
                    r_rdata  <= mem_data_out;
                    r_mem_we <= 1'b0;
                    r_ack0   <= ~r_winner;
                    r_ack1   <= r_winner;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata       = r_rdata;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_we      = r_mem_we;
    assign busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the width of every address port.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of every data port.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: access request from requester 0 (fetch) and requester 1 (data).
REQ-006 The block SHALL have ports addr0 and addr1, input, ADDR_W bits each: the requested word address.
REQ-007 The block SHALL have ports wdata0 and wdata1, input, DATA_W bits each: the write data.
REQ-008 The block SHALL have ports we0 and we1, input, 1 bit each: 1 = write, 0 = read.
REQ-009 The block SHALL have ports ack0 and ack1, output, 1 bit each: a one-cycle completion pulse.
REQ-010 The block SHALL have port rdata, output, DATA_W bits: read data, valid while ack0 or ack1 is high.
REQ-011 The block SHALL have ports mem_address, mem_data_in and mem_we, outputs of ADDR_W, DATA_W and 1 bits, which drive the memory controller.
REQ-012 The block SHALL have port mem_data_out, input, DATA_W bits: read data returned by the memory controller.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The state machine SHALL have three states:
- IDLE
- ACCESS
- DONE
REQ-015 In IDLE, if req0 or req1 is high at a rising edge, the block SHALL do the following on that edge:
- select a winner;
- register the winner's address, write data and write enable into mem_address, mem_data_in and mem_we;
- move to ACCESS.
REQ-016 With no request in IDLE, the block SHALL stay in IDLE with mem_we = 0.
REQ-017 ACCESS SHALL last exactly one cycle, during which the memory controller performs its falling-edge access with the held address, data and we.
REQ-018 On the rising edge that leaves ACCESS, the block SHALL do the following:
- capture mem_data_out into rdata;
- clear mem_we;
- assert the winner's ack;
- move to DONE.
REQ-019 DONE SHALL last exactly one cycle with the winner's ack high, after which the state SHALL return to IDLE and ack SHALL deassert.
REQ-020 Latency from the edge that samples req to the cycle in which ack is high SHALL be exactly 2 cycles, and the minimum interval between grants SHALL be 3 cycles.
REQ-021 ack0 and ack1 SHALL never be high in the same cycle.
REQ-022 A requester SHALL hold req, addr, wdata and we stable until it sees ack, and SHALL drop req at the edge that ends DONE; req is not sampled in ACCESS or DONE.
REQ-023 Changes on the losing requester's inputs SHALL NOT affect mem_address, mem_data_in or mem_we.
REQ-024 rdata for a write access SHALL be whatever mem_data_out presents; requesters SHALL ignore it.
REQ-025 mem_address and mem_data_in SHALL hold their last values in IDLE, and mem_we SHALL be high only in ACCESS.

Reset
REQ-026 When reset_n is low, the block SHALL immediately force the following values regardless of clock:
- state = IDLE
- ack0 = ack1 = 0
- busy = 0
- mem_we = 0
- mem_address = 0
- mem_data_in = 0
- rdata = 0
- the round-robin pointer to favour requester 0
REQ-027 Reset asserted during ACCESS or DONE SHALL abort the transaction with no ack issued, and the aborted requester SHALL re-request after reset.

Configuration
REQ-028 With macro MEM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin:
- on simultaneous requests, the requester not granted most recently wins;
- a one-bit pointer updates on every grant.
REQ-029 Without MEM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests, and no pointer SHALL exist.

Verification
REQ-030 Reset, then a req0 read of addr0 = 0x0800 with the RAM at that word = 0xDEADBEEF, SHALL produce mem_address = 0x0800 in ACCESS and ack0 two cycles after the request edge with rdata = 0xDEADBEEF.
REQ-031 A req1 write of addr1 = 0x0801, wdata1 = 0x12345678 followed by a req0 read of 0x0801 SHALL show mem_we = 1 for exactly one cycle, then ack0 with rdata = 0x12345678.
REQ-032 req0 and req1 held high together for four grants SHALL produce the grant order 0,1,0,1 with the macro defined and 0,0,0,0 without it.
REQ-033 A read of addr = 0x0020 with io_in = 4'b1010 SHALL return rdata = 0x0000000A, and a read of addr = 0x0100 (unmapped) SHALL return rdata = 0.
REQ-034 reset_n pulled low in the ACCESS cycle of a write SHALL immediately give mem_we = 0, state IDLE and no ack, and the first request after release SHALL complete normally.
